adc_result_fifo: RTL

- Sits directly downstream of SARADC, upstream of SPI.
- Captures each completed 5-bit conversion when the ADC's valid strobe rises and buffers it in a small synchronous FIFO.
- SPI pops buffered samples through a simple read handshake.
- Reports fill level, empty/full status and a sticky overflow flag for the register map.

---
 rtl/adc_result_fifo_if.sv | 36 +++
 rtl/adc_result_fifo.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/adc_result_fifo_if.sv
// rtl/adc_result_fifo_if.sv - capture/readout bundle between SARADC, the result FIFO and SPI
//
// Purpose: groups the SARADC capture inputs, the SPI pop handshake and the
// status outputs of adc_result_fifo.
// Modports:
//   master - the SARADC/SPI/register side; drives capture, flush, pop and ovf_clr
//   slave  - the FIFO; drives rd_data, rd_valid, empty, full, level and ovf
interface adc_result_fifo_if #(
    parameter int DEPTH = 8,
    parameter int DW    = 5
);
    localparam int AW = $clog2(DEPTH);

    logic          adc_valid;
    logic [DW-1:0] adc_result;
    logic          cap_en;
    logic          flush;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          ovf;
    logic          ovf_clr;

    modport master (
        output adc_valid, adc_result, cap_en, flush, rd_en, ovf_clr,
        input  rd_data, rd_valid, empty, full, level, ovf
    );

    modport slave (
        input  adc_valid, adc_result, cap_en, flush, rd_en, ovf_clr,
        output rd_data, rd_valid, empty, full, level, ovf
    );
endinterface

// File: rtl/adc_result_fifo.sv
// rtl/adc_result_fifo.sv - SARADC result capture FIFO with SPI pop side and sticky overflow
//
// Purpose: captures one SARADC result per rising edge of adc_valid (gated by
// cap_en) into a DEPTH-entry FIFO that SPI drains through rd_en/rd_valid.
// Optional feature macro ADC_AVG_EN: when defined, every four captured samples
// are summed and their truncated average is pushed instead of each sample.
// Ports:
//   clk   - system clock shared by SARADC and SPI-side logic
//   rst_n - asynchronous active-low reset
//   bus   - adc_result_fifo_if.slave: adc_valid, adc_result, cap_en, flush,
//           rd_en, ovf_clr in; rd_data, rd_valid, empty, full, level, ovf out
module adc_result_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    adc_result_fifo_if.slave  bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_LVL  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_valid_q;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          r_ovf;

    logic          w_cap;
    logic          w_push_req;
    logic [DW-1:0] w_push_data;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_ovf_set;

    // valid_q tracks adc_valid regardless of cap_en, so enabling capture while
    // a conversion is already high does not produce a late push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= bus.adc_valid;
        end
    end

    assign w_cap = bus.adc_valid & ~r_valid_q & bus.cap_en;

`ifdef ADC_AVG_EN
    logic [1:0]    r_cnt;
    logic [DW+1:0] r_acc;
    logic [DW+1:0] w_sum;

    assign w_sum       = r_acc + {2'b00, bus.adc_result};
    assign w_push_req  = w_cap & (r_cnt == 2'd3);
    assign w_push_data = w_sum[DW+1:2];

    // The partial sum is only touched on a capture, so cap_en low holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_acc <= '0;
        end else if (bus.flush) begin
            r_cnt <= 2'd0;
            r_acc <= '0;
        end else if (w_cap) begin
            r_cnt <= r_cnt + 2'd1;
            r_acc <= (r_cnt == 2'd3) ? '0 : w_sum;
        end
    end
`else
    assign w_push_req  = w_cap;
    assign w_push_data = bus.adc_result;
`endif

    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);

    // A pop on a full FIFO frees the slot the simultaneous push writes into;
    // on an empty FIFO the pop is refused, so there is no read-through.
    assign w_pop     = bus.rd_en & ~w_empty & ~bus.flush;
    assign w_push_ok = w_push_req & ~bus.flush & (~w_full | w_pop);
    assign w_ovf_set = w_push_req & ~bus.flush & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (bus.flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_push_ok) begin
                r_wptr <= r_wptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rd_data <= r_mem[r_rptr];
                r_rptr    <= r_rptr + ONE_PTR;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + ONE_LVL;
                2'b01:   r_level <= r_level - ONE_LVL;
                default: r_level <= r_level;
            endcase
        end
    end

    // Set has priority over clear so a coincident overflow is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.level    = r_level;
    assign bus.ovf      = r_ovf;
endmodule
